sha256_bit_sequencer: RTL and testbench

//  Master sequencer for the bit-serial SHA-256 core. Generates bclk for all delay lines/serial ALUs.

---
 rtl/sha256_seq_pkg.sv | 19 +
 rtl/sha256_bit_sequencer_bclk_divider.sv | 49 ++++
 rtl/sha256_bit_sequencer.sv | 133 +++++++++++++
 tb/tb_sha256_bit_sequencer.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/sha256_seq_pkg.sv
// Shared types and constants for the bit-serial SHA-256 sequencer.
// Optional stall support is enabled by defining BSEQ_STALL_EN.
package sha256_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FINAL = 2'd2
  } seq_state_e;

  localparam int SHA_W_WORD    = 32;
  localparam int SHA_ROUNDS    = 64;
  localparam int SHA_MSG_WORDS = 16;

  function automatic int cw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sha256_bit_sequencer_bclk_divider.sv
// bclk generator: divides clk by 2*BCLK_DIV and flags the play (falling) edge.
// Frozen when en_i is low; clr_i returns it to count 0 with bclk low.
module bclk_divider
  import sha256_seq_pkg::*;
#(
  parameter int BCLK_DIV = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic bclk_o,
  output logic fall_o
);

  localparam int DW = cw(BCLK_DIV);
  localparam logic [DW-1:0] DIV_MAX = DW'(BCLK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bclk_q, bclk_d;
  logic          tick;

  always_comb begin
    tick   = en_i && !clr_i && (div_q == DIV_MAX);
    div_d  = div_q;
    bclk_d = bclk_q;
    if (clr_i) begin
      div_d  = '0;
      bclk_d = 1'b0;
    end else if (en_i) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) bclk_d = ~bclk_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_q  <= '0;
      bclk_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      bclk_q <= bclk_d;
    end
  end

  assign bclk_o = bclk_q;
  assign fall_o = tick && bclk_q;

endmodule

// File: rtl/sha256_bit_sequencer.sv
// Master bit/round sequencer and bclk source for the bit-serial SHA-256 core.
// Define BSEQ_STALL_EN to add the stall input that freezes all sequencing.
module sha256_bit_sequencer
  import sha256_seq_pkg::*;
#(
  parameter  int W_WORD     = SHA_W_WORD,
  parameter  int ROUNDS     = SHA_ROUNDS,
  parameter  int MSG_WORDS  = SHA_MSG_WORDS,
  parameter  int BCLK_DIV   = 2,
  parameter  int FINAL_BITS = 32,
  localparam int BW         = cw(W_WORD),
  localparam int RW         = cw(ROUNDS),
  localparam int FW         = cw(FINAL_BITS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
`ifdef BSEQ_STALL_EN
  input  logic          stall,
`endif
  output logic          bclk,
  output logic [BW-1:0] bit_idx,
  output logic [RW-1:0] round_idx,
  output logic          word_first,
  output logic          word_last,
  output logic          msg_phase,
  output logic          final_ph,
  output logic          busy,
  output logic          done
);

  seq_state_e    state_q, state_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [RW-1:0] rnd_q, rnd_d;
  logic [FW-1:0] fin_q, fin_d;
  logic          clr, fall, frz, done_c;
  logic          bit_last, rnd_last, fin_last;

`ifdef BSEQ_STALL_EN
  assign frz = stall;
`else
  assign frz = 1'b0;
`endif

  bclk_divider #(
    .BCLK_DIV(BCLK_DIV)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  ((state_q != IDLE) && !frz),
    .clr_i (clr),
    .bclk_o(bclk),
    .fall_o(fall)
  );

  assign bit_last = (bit_q == BW'(W_WORD - 1));
  assign rnd_last = (rnd_q == RW'(ROUNDS - 1));
  assign fin_last = (fin_q == FW'(FINAL_BITS - 1));

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    rnd_d   = rnd_q;
    fin_d   = fin_q;
    clr     = 1'b0;
    done_c  = 1'b0;
    if (state_q != IDLE && abort) begin
      state_d = IDLE;
      clr     = 1'b1;
      bit_d   = '0;
      rnd_d   = '0;
      fin_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          clr = 1'b1;
          if (start) state_d = RUN;
        end
        RUN: begin
          if (fall) begin
            bit_d = bit_last ? '0 : bit_q + 1'b1;
            if (bit_last && rnd_last) begin
              state_d = FINAL;
              fin_d   = '0;
            end else if (bit_last) begin
              rnd_d = rnd_q + 1'b1;
            end
          end
        end
        FINAL: begin
          // round_idx stays parked on the last round here
          if (fall) begin
            bit_d = bit_last ? '0 : bit_q + 1'b1;
            fin_d = fin_q + 1'b1;
            if (fin_last) begin
              state_d = IDLE;
              bit_d   = '0;
              rnd_d   = '0;
              fin_d   = '0;
              done_c  = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      bit_q   <= '0;
      rnd_q   <= '0;
      fin_q   <= '0;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      rnd_q   <= rnd_d;
      fin_q   <= fin_d;
    end
  end

  assign busy       = (state_q != IDLE);
  assign bit_idx    = bit_q;
  assign round_idx  = rnd_q;
  assign word_first = busy && (bit_q == '0);
  assign word_last  = busy && bit_last;
  assign msg_phase  = (state_q == RUN) && (int'(rnd_q) < MSG_WORDS);
  assign final_ph   = (state_q == FINAL);
  assign done       = done_c;

endmodule

// File: tb/tb_sha256_bit_sequencer.sv
// Directed self-checking bench for sha256_bit_sequencer (BCLK_DIV=2).
// Stall scenario is included when BSEQ_STALL_EN is defined.
module tb_sha256_bit_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       stall = 1'b0;
  logic       bclk, word_first, word_last, msg_phase, final_ph, busy, done;
  logic [4:0] bit_idx;
  logic [5:0] round_idx;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  sha256_bit_sequencer #(.BCLK_DIV(2)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
`ifdef BSEQ_STALL_EN
    .stall     (stall),
`endif
    .bclk      (bclk),
    .bit_idx   (bit_idx),
    .round_idx (round_idx),
    .word_first(word_first),
    .word_last (word_last),
    .msg_phase (msg_phase),
    .final_ph  (final_ph),
    .busy      (busy),
    .done      (done)
  );

  wire [17:0] all_out = {bclk, bit_idx, round_idx, word_first,
                         word_last, msg_phase, final_ph, busy, done};

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One block from start accept to the clk after done, with per-rise monitoring.
  task automatic run_block(input bit hold, input bit do_stall, input string nm);
    int cyc, lat, rises, msg_r, fin_r;
    int bad_seq, bad_gap, bad_wf, busy_lo, last_rise, gap_exp, frz_bad;
    int exp_bit, exp_rnd;
    bit stalled;
    logic prev;
    lat = -1; rises = 0; msg_r = 0; fin_r = 0;
    bad_seq = 0; bad_gap = 0; bad_wf = 0; busy_lo = 0;
    last_rise = -1; gap_exp = 4; frz_bad = 0; stalled = 0;
    start = 1'b1;
    tick;
    start = hold;
    cyc = 1;
    prev = 1'b0;
    while (cyc <= 9000) begin
      if (!busy) busy_lo++;
      if (bclk && !prev) begin
        exp_bit = rises % 32;
        exp_rnd = (rises < 2048) ? rises / 32 : 63;
        if (bit_idx !== 5'(exp_bit) || round_idx !== 6'(exp_rnd)) bad_seq++;
        if (word_first !== (exp_bit == 0)) bad_wf++;
        if (word_last !== (exp_bit == 31)) bad_wf++;
        if (cyc != last_rise + gap_exp) bad_gap++;
        gap_exp = 4;
        last_rise = cyc;
        if (msg_phase) msg_r++;
        if (final_ph) fin_r++;
        rises++;
`ifdef BSEQ_STALL_EN
        if (do_stall && !stalled && round_idx == 6'd3 && bit_idx == 5'd12) begin
          stalled = 1'b1;
          stall = 1'b1;
          for (int i = 0; i < 7; i++) begin
            tick;
            cyc++;
            if (!(bclk === 1'b1 && bit_idx === 5'd12 && round_idx === 6'd3)) frz_bad++;
            if (done !== 1'b0) frz_bad++;
            if (i == 6) stall = 1'b0;
          end
          gap_exp = 11;
        end
`endif
      end
      if (done) begin
        lat = cyc;
        break;
      end
      prev = bclk;
      tick;
      cyc++;
    end
    chk({nm, "_latency"}, lat, do_stall ? 8327 : 8320);
    chk({nm, "_rises"}, rises, 2080);
    chk({nm, "_msg_rises"}, msg_r, 512);
    chk({nm, "_final_rises"}, fin_r, 32);
    chk({nm, "_bit_round_seq"}, bad_seq, 0);
    chk({nm, "_word_flags"}, bad_wf, 0);
    chk({nm, "_bclk_period"}, bad_gap, 0);
    chk({nm, "_busy_held"}, busy_lo, 0);
`ifdef BSEQ_STALL_EN
    if (do_stall) begin
      chk({nm, "_stall_hit"}, stalled, 1);
      chk({nm, "_frozen"}, frz_bad, 0);
    end
`endif
    tick;
    chk({nm, "_done_width"}, {done, busy}, 2'b00);
  endtask

  initial begin
    int n;
    bit seen_done;

    // Reset state
    #12;
    chk("reset_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    chk("idle_outputs", all_out, 0);

    // abort alone in IDLE does nothing
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_idle", busy, 0);

    // Full run
    run_block(1'b0, 1'b0, "run1");

    // Reset mid-run at round 10, bit 5
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    while (!(round_idx == 6'd10 && bit_idx == 5'd5) && n < 3000) begin
      tick;
      n++;
    end
    chk("reach_r10b5", {round_idx, bit_idx}, {6'd10, 5'd5});
    #2 rst_n = 1'b0;
    #1 chk("async_reset_outputs", all_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick;
    run_block(1'b0, 1'b0, "after_reset");

    // Abort at round 20
    start = 1'b1;
    tick;
    start = 1'b0;
    n = 0;
    seen_done = 1'b0;
    while (round_idx != 6'd20 && n < 4000) begin
      if (done) seen_done = 1'b1;
      tick;
      n++;
    end
    chk("reach_r20", round_idx, 20);
    abort = 1'b1;
    if (done) seen_done = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_state", {busy, bclk, round_idx, bit_idx}, 0);
    for (int i = 0; i < 4; i++) begin
      if (done) seen_done = 1'b1;
      tick;
    end
    chk("abort_no_done", seen_done, 0);
    // start together with abort in IDLE: start wins
    start = 1'b1;
    abort = 1'b1;
    tick;
    start = 1'b0;
    abort = 1'b0;
    chk("start_beats_abort", busy, 1);
    n = 0;
    while (!bclk && n < 20) begin
      tick;
      n++;
    end
    chk("restart_first_rise", {bclk, round_idx, bit_idx, msg_phase}, {1'b1, 6'd0, 5'd0, 1'b1});
    chk("restart_rise_delay", n, 2);
    abort = 1'b1;
    tick;
    abort = 1'b0;
    chk("abort_clean", {busy, bclk}, 2'b00);

    // start held high: back-to-back runs, each accepted only from IDLE
    run_block(1'b1, 1'b0, "held1");
    run_block(1'b1, 1'b0, "held2");
    start = 1'b0;
    tick;
    chk("held_end_idle", busy, 0);

`ifdef BSEQ_STALL_EN
    run_block(1'b0, 1'b1, "stall");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
